// File: rtl/crc_pkg.sv
// ---------------------------------------------------------------------------
// crc_pkg
// Shared definitions for the serial CRC frame sequencer.
//   state_e   : controller states (IDLE -> MSG -> CRC -> DONE -> IDLE)
//   DEF_POLY  : default generator polynomial, implicit x^3 term (x^3+x+1)
//   DEF_INIT  : default CRC register value at frame start
// ---------------------------------------------------------------------------
package crc_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MSG  = 2'd1,
      S_CRC  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   localparam logic [2:0] DEF_POLY = 3'b011;
   localparam logic [2:0] DEF_INIT = 3'b000;

endpackage : crc_pkg

// File: rtl/crc_serial_core.sv
// ---------------------------------------------------------------------------
// crc_serial_core
// Bit-serial CRC LFSR. One step per message bit; init has priority over step.
// Ports:
//   clk     in   1      clock, rising edge
//   clrn    in   1      asynchronous active-low reset (register -> INIT)
//   init    in   1      load INIT (frame start)
//   step    in   1      advance the LFSR by one message bit
//   bit_in  in   1      message bit being shifted in
//   crc     out  CRC_W  current CRC register
// ---------------------------------------------------------------------------
module crc_serial_core
   import crc_pkg::*;
#(
   parameter int                CRC_W = 3,
   parameter logic [CRC_W-1:0]  POLY  = CRC_W'(DEF_POLY),
   parameter logic [CRC_W-1:0]  INIT  = CRC_W'(DEF_INIT)
) (
   input  logic              clk,
   input  logic              clrn,
   input  logic              init,
   input  logic              step,
   input  logic              bit_in,
   output logic [CRC_W-1:0]  crc
);

   logic [CRC_W-1:0] crc_q;
   logic [CRC_W-1:0] crc_d;
   logic             fb;

   always_comb begin
      crc_d = crc_q;
      fb    = bit_in ^ crc_q[CRC_W-1];
      if (init) begin
         crc_d = INIT;
      end else if (step) begin
         crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         crc_q <= INIT;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;

endmodule : crc_serial_core

// File: rtl/crc_frame_ctrl.sv
// ---------------------------------------------------------------------------
// crc_frame_ctrl
// Accepts one MSG_W-bit word per frame and streams it MSB-first on a serial
// link, followed by the CRC_W remainder bits MSB-first, then pulses done.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and s_out/s_last hold their value
// while s_valid=1 and s_ready=0.
// Ports:
//   clk       in   1      clock, rising edge
//   clrn      in   1      asynchronous active-low reset
//   in_valid  in   1      message word offered
//   in_ready  out  1      high only in IDLE
//   in_data   in   MSG_W  message word
//   abort     in   1      synchronous frame abort (ignored in IDLE)
//   s_valid   out  1      serial bit valid
//   s_ready   in   1      downstream accepts serial bit
//   s_out     out  1      serial bit
//   s_last    out  1      high with the final CRC bit
//   crc_out   out  CRC_W  remainder of the last completed frame
//   done      out  1      one-cycle pulse at frame completion
// ---------------------------------------------------------------------------
module crc_frame_ctrl
   import crc_pkg::*;
#(
   parameter int                MSG_W = 8,
   parameter int                CRC_W = 3,
   parameter logic [CRC_W-1:0]  POLY  = CRC_W'(DEF_POLY),
   parameter logic [CRC_W-1:0]  INIT  = CRC_W'(DEF_INIT)
) (
   input  logic              clk,
   input  logic              clrn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [MSG_W-1:0]  in_data,
   input  logic              abort,
   output logic              s_valid,
   input  logic              s_ready,
   output logic              s_out,
   output logic              s_last,
   output logic [CRC_W-1:0]  crc_out,
   output logic              done
);

   localparam int CNT_MAX = (MSG_W > CRC_W) ? MSG_W : CRC_W;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MSG_W - 1);
   localparam logic [CNT_W-1:0] CRC_LAST = CNT_W'(CRC_W - 1);

   state_e            state_q, state_d;
   logic [MSG_W-1:0]  shift_q, shift_d;
   logic [CRC_W-1:0]  oshift_q, oshift_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CRC_W-1:0]  crc_out_q, crc_out_d;

   logic              crc_init;
   logic              crc_step;
   logic [CRC_W-1:0]  crc_val;
   logic [CRC_W-1:0]  crc_nxt;
   logic              fb;
   logic              beat;

   crc_serial_core #(
      .CRC_W (CRC_W),
      .POLY  (POLY),
      .INIT  (INIT)
   ) u_core (
      .clk    (clk),
      .clrn   (clrn),
      .init   (crc_init),
      .step   (crc_step),
      .bit_in (shift_q[MSG_W-1]),
      .crc    (crc_val)
   );

   // Outputs decode straight from registered state, so they are stable
   // for the whole cycle and hold through stalls.
   always_comb begin
      in_ready = (state_q == S_IDLE);
      s_valid  = (state_q == S_MSG) || (state_q == S_CRC);
      done     = (state_q == S_DONE);
      s_out    = 1'b0;
      s_last   = 1'b0;
      if (state_q == S_MSG) begin
         s_out = shift_q[MSG_W-1];
      end else if (state_q == S_CRC) begin
         s_out  = oshift_q[CRC_W-1];
         s_last = (cnt_q == CRC_LAST);
      end
   end

   assign beat    = s_valid && s_ready;
   assign crc_out = crc_out_q;

   // The value the core will hold after the final message beat; it is
   // captured into the output shifter on that same edge so the CRC phase
   // starts without a gap cycle.
   assign fb      = shift_q[MSG_W-1] ^ crc_val[CRC_W-1];
   assign crc_nxt = {crc_val[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      oshift_d  = oshift_q;
      cnt_d     = cnt_q;
      crc_out_d = crc_out_q;
      crc_init  = 1'b0;
      crc_step  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               shift_d  = in_data;
               cnt_d    = '0;
               crc_init = 1'b1;
               state_d  = S_MSG;
            end
         end
         S_MSG: begin
            // abort wins over a coincident beat: the beat is void
            if (abort) begin
               state_d = S_IDLE;
            end else if (beat) begin
               crc_step = 1'b1;
               shift_d  = shift_q << 1;
               cnt_d    = cnt_q + CNT_W'(1);
               if (cnt_q == MSG_LAST) begin
                  oshift_d = crc_nxt;
                  cnt_d    = '0;
                  state_d  = S_CRC;
               end
            end
         end
         S_CRC: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (beat) begin
               oshift_d = oshift_q << 1;
               cnt_d    = cnt_q + CNT_W'(1);
               if (cnt_q == CRC_LAST) begin
                  crc_out_d = crc_val;
                  cnt_d     = '0;
                  state_d   = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q   <= S_IDLE;
         shift_q   <= '0;
         oshift_q  <= '0;
         cnt_q     <= '0;
         crc_out_q <= '0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         oshift_q  <= oshift_d;
         cnt_q     <= cnt_d;
         crc_out_q <= crc_out_d;
      end
   end

endmodule : crc_frame_ctrl
